// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// constant-friendly clog2 for sizing index and counter fields.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request/data bundle plus the FIFO write pins and arbiter status.
// master = arbiter, slave = producers/FIFO/environment.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int IDX_W = clog2(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            gnt;
  logic                        fifo_cs;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_full;
  logic [IDX_W-1:0]            owner_id;
  logic                        busy;
  logic [CNT_WIDTH-1:0]        wr_count;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_cs, fifo_wr_en, fifo_data_in, owner_id, busy, wr_count
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_cs, fifo_wr_en, fifo_data_in, owner_id, busy, wr_count
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate req so ptr sits at bit 0, find first set,
// then rotate the offset back into an absolute requester index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    any_o = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off   = IW'(j);
        any_o = 1'b1;
      end
    end
    // Explicit wrap so non-power-of-two N stays in range.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o    = sum[IW-1:0];
    onehot_o = '0;
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write-port arbiter with bounded bursts. Grant is
// combinational so the winning word lands in the FIFO on the same edge.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = clog2(N_REQ);
  localparam int BW = clog2(BURST_LEN + 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]  wr_count_q;
  logic [N_REQ-1:0]      pick_oh, gnt, gnt_o;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_mux;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(N_REQ - 1)) ? '0 : x + IW'(1);
  endfunction

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign cnt_inc = burst_cnt_q + BW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any && !bus.fifo_full) begin
          gnt     = pick_oh;
          owner_d = pick_idx;
          if (BURST_LEN == 1) begin
            rr_ptr_d = wrap_inc(pick_idx);
          end else begin
            burst_cnt_d = BW'(1);
            state_d     = BURST;
          end
        end
      end
      BURST: begin
        // Owner dropping req ends the burst early; full with req held just stalls.
        if (!bus.req[owner_q]) begin
          state_d     = IDLE;
          rr_ptr_d    = wrap_inc(owner_q);
          burst_cnt_d = '0;
        end else if (!bus.fifo_full) begin
          gnt[owner_q] = 1'b1;
          burst_cnt_d  = cnt_inc;
          if (cnt_inc == BW'(BURST_LEN)) begin
            state_d     = IDLE;
            rr_ptr_d    = wrap_inc(owner_q);
            burst_cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // IDLE grants depend only on req, so block them while reset is held.
  assign gnt_o = rst ? '0 : gnt;
  assign wr_en = |gnt_o;

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_o[i]) data_mux = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      if (wr_en) wr_count_q <= wr_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.gnt          = gnt_o;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_cs      = wr_en;
  assign bus.fifo_data_in = data_mux;
  assign bus.owner_id     = owner_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench: three arbiters (BURST_LEN 1, 2, 4) on shared requests, depth-8 FIFO
// models with readers on the first two, scoreboards for grants and read data.
module tb_fifo_wr_arbiter;

  logic         clk, rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         rd1, rd2, full1, full2;
  logic [31:0]  f1[$], o1[$], f2[$], o2[$];
  int           exp_g[$];
  logic [31:0]  exp_d[$];
  int           n_cmp, n_bad;
  logic [31:0]  dw [4];

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) if1 ();
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) if2 ();
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) if4 ();

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .BURST_LEN(1), .CNT_WIDTH(16))
    u_bl1 (.clk(clk), .rst(rst), .bus(if1.master));
  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .BURST_LEN(2), .CNT_WIDTH(16))
    u_bl2 (.clk(clk), .rst(rst), .bus(if2.master));
  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .BURST_LEN(4), .CNT_WIDTH(16))
    u_bl4 (.clk(clk), .rst(rst), .bus(if4.master));

  assign if1.req = req;  assign if1.req_data = req_data;  assign if1.fifo_full = full1;
  assign if2.req = req;  assign if2.req_data = req_data;  assign if2.fifo_full = full2;
  assign if4.req = req;  assign if4.req_data = req_data;  assign if4.fifo_full = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Depth-8 FIFO models: read pops before the same-edge write is stored.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f1.delete();
      full1 <= 1'b0;
    end else begin
      if (rd1 && f1.size() > 0) o1.push_back(f1.pop_front());
      if (if1.fifo_wr_en) f1.push_back(if1.fifo_data_in);
      full1 <= (f1.size() >= 8);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f2.delete();
      full2 <= 1'b0;
    end else begin
      if (rd2 && f2.size() > 0) o2.push_back(f2.pop_front());
      if (if2.fifo_wr_en) f2.push_back(if2.fifo_data_in);
      full2 <= (f2.size() >= 8);
    end
  end

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_g.delete();
    exp_d.delete();
  endtask

  task automatic test_reset();
    req = 4'b1111;
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({if1.gnt, if2.gnt, if4.gnt} !== 12'h0) begin n_bad++;
      $display("FAIL reset_gnt: got %h want 000", {if1.gnt, if2.gnt, if4.gnt}); end
    n_cmp++; if ({if2.fifo_wr_en, if2.fifo_cs, if2.busy} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctrl: got %b want 000", {if2.fifo_wr_en, if2.fifo_cs, if2.busy}); end
    n_cmp++; if (if2.wr_count !== 16'd0) begin n_bad++;
      $display("FAIL reset_wr_count: got %0d want 0", if2.wr_count); end
    n_cmp++; if (if2.owner_id !== 2'd0) begin n_bad++;
      $display("FAIL reset_owner: got %0d want 0", if2.owner_id); end
  endtask

  task automatic test_single();
    logic [31:0] a, d;
    do_reset();
    o2.delete();
    req = 4'b0010; exp_d.push_back(32'd10); #1;
    n_cmp++; if (if2.gnt !== 4'b0010) begin n_bad++;
      $display("FAIL single_gnt: got %b want 0010", if2.gnt); end
    n_cmp++; if (if2.fifo_data_in !== 32'd10) begin n_bad++;
      $display("FAIL single_data: got %0d want 10", if2.fifo_data_in); end
    @(negedge clk); req = '0; #1;
    n_cmp++; if ({if2.gnt, if2.busy} !== 5'b0000_1) begin n_bad++;
      $display("FAIL single_drop: got gnt=%b busy=%b want 0000/1", if2.gnt, if2.busy); end
    @(negedge clk); #1;
    n_cmp++; if (if2.busy !== 1'b0) begin n_bad++;
      $display("FAIL single_idle: got busy=%b want 0", if2.busy); end
    // Requesters 0,1,3 ask; search must start at 2, so 3 wins. Withdrawn before the edge.
    req = 4'b1011; #1;
    n_cmp++; if (if2.gnt !== 4'b1000) begin n_bad++;
      $display("FAIL single_next: got %b want 1000", if2.gnt); end
    req = '0;
    rd2 = 1'b1; repeat (3) @(negedge clk); rd2 = 1'b0;
    n_cmp++; if (o2.size() !== exp_d.size()) begin n_bad++;
      $display("FAIL single_rd_count: got %0d want %0d", o2.size(), exp_d.size()); end
    while (o2.size() > 0 && exp_d.size() > 0) begin
      a = o2.pop_front(); d = exp_d.pop_front();
      n_cmp++; if (a !== d) begin n_bad++; $display("FAIL single_rd: got %0d want %0d", a, d); end
    end
  endtask

  task automatic test_rr_bl1();
    int e;
    logic [31:0] a, d;
    do_reset();
    o1.delete(); rd1 = 1'b1;
    for (int k = 0; k < 8; k++) begin exp_g.push_back(k % 4); exp_d.push_back(dw[k % 4]); end
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      if (exp_g.size() == 0) req = '0;
      #1;
      if (if1.gnt !== 4'b0) begin
        e = (exp_g.size() > 0) ? exp_g.pop_front() : -1;
        n_cmp++; if (e < 0 || if1.gnt !== (4'b0001 << e) || if1.fifo_data_in !== dw[e]) begin n_bad++;
          $display("FAIL rr1_gnt: got %b/%0d want idx %0d", if1.gnt, if1.fifo_data_in, e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_g.size() != 0) begin n_bad++;
      $display("FAIL rr1_missing: got %0d grants outstanding want 0", exp_g.size()); end
    rd1 = 1'b0;
    n_cmp++; if (o1.size() !== exp_d.size()) begin n_bad++;
      $display("FAIL rr1_rd_count: got %0d want %0d", o1.size(), exp_d.size()); end
    while (o1.size() > 0 && exp_d.size() > 0) begin
      a = o1.pop_front(); d = exp_d.pop_front();
      n_cmp++; if (a !== d) begin n_bad++; $display("FAIL rr1_rd: got %0d want %0d", a, d); end
    end
  endtask

  task automatic test_burst2();
    int e;
    do_reset();
    rd2 = 1'b1;
    for (int k = 0; k < 8; k++) exp_g.push_back(k / 2);
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (exp_g.size() == 0) req = '0;
      #1;
      if (if2.gnt !== 4'b0) begin
        e = (exp_g.size() > 0) ? exp_g.pop_front() : -1;
        n_cmp++; if (e < 0 || if2.gnt !== (4'b0001 << e)) begin n_bad++;
          $display("FAIL burst2_gnt: got %b want idx %0d", if2.gnt, e); end
      end
      @(negedge clk);
    end
    rd2 = 1'b0;
    n_cmp++; if (exp_g.size() != 0) begin n_bad++;
      $display("FAIL burst2_missing: got %0d outstanding want 0", exp_g.size()); end
    n_cmp++; if (if2.wr_count !== 16'd8) begin n_bad++;
      $display("FAIL burst2_wr_count: got %0d want 8", if2.wr_count); end
  endtask

  task automatic test_fill();
    int e, g;
    do_reset();
    rd2 = 1'b0;
    for (int k = 0; k < 8; k++) exp_g.push_back(k / 2);
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      e = (exp_g.size() > 0) ? exp_g.pop_front() : -1;
      n_cmp++; if (e < 0 || if2.gnt !== (4'b0001 << e)) begin n_bad++;
        $display("FAIL fill_gnt: got %b want idx %0d", if2.gnt, e); end
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if ({if2.fifo_full, if2.gnt, if2.fifo_wr_en} !== 6'b1_0000_0 || if2.fifo_data_in !== 32'd0) begin n_bad++;
        $display("FAIL fill_stall: got full=%b gnt=%b wr=%b data=%0d want 1/0000/0/0",
                 if2.fifo_full, if2.gnt, if2.fifo_wr_en, if2.fifo_data_in); end
      @(negedge clk);
    end
    rd2 = 1'b1; @(negedge clk); rd2 = 1'b0; #1;
    n_cmp++; if (if2.gnt !== 4'b0001) begin n_bad++;
      $display("FAIL fill_after_read: got %b want 0001", if2.gnt); end
    g = 0;
    for (int c = 0; c < 6; c++) begin
      if (if2.gnt !== 4'b0) g++;
      @(negedge clk); #1;
    end
    n_cmp++; if (g != 1) begin n_bad++;
      $display("FAIL fill_one_grant: got %0d grants want 1", g); end
    req = '0;
  endtask

  task automatic test_burst_break();
    do_reset();
    req = 4'b0100; #1;
    n_cmp++; if (if4.gnt !== 4'b0100) begin n_bad++;
      $display("FAIL brk_first: got %b want 0100", if4.gnt); end
    @(negedge clk); #1;
    n_cmp++; if ({if4.gnt, if4.busy} !== 5'b0100_1) begin n_bad++;
      $display("FAIL brk_second: got %b/%b want 0100/1", if4.gnt, if4.busy); end
    @(negedge clk); req = 4'b1001; #1;
    n_cmp++; if ({if4.gnt, if4.busy} !== 5'b0000_1) begin n_bad++;
      $display("FAIL brk_drop: got %b/%b want 0000/1", if4.gnt, if4.busy); end
    @(negedge clk); #1;
    n_cmp++; if ({if4.gnt, if4.busy} !== 5'b1000_0) begin n_bad++;
      $display("FAIL brk_next: got %b/%b want 1000/0", if4.gnt, if4.busy); end
    n_cmp++; if (if4.wr_count !== 16'd2) begin n_bad++;
      $display("FAIL brk_wr_count: got %0d want 2", if4.wr_count); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({if4.busy, if4.gnt} !== 5'b1_0001) begin n_bad++;
      $display("FAIL mid_pre: got busy=%b gnt=%b want 1/0001", if4.busy, if4.gnt); end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({if4.gnt, if4.fifo_wr_en, if4.busy} !== 6'b0) begin n_bad++;
        $display("FAIL mid_rst: got gnt=%b wr=%b busy=%b want 0", if4.gnt, if4.fifo_wr_en, if4.busy); end
      @(negedge clk);
    end
    rst = 1'b0; #1;
    n_cmp++; if (if4.gnt !== 4'b0001) begin n_bad++;
      $display("FAIL mid_first: got %b want 0001", if4.gnt); end
    n_cmp++; if (if4.wr_count !== 16'd0) begin n_bad++;
      $display("FAIL mid_wr_count: got %0d want 0", if4.wr_count); end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req = '0; rd1 = 1'b0; rd2 = 1'b0;
    dw[0] = 32'd1; dw[1] = 32'd10; dw[2] = 32'd100; dw[3] = 32'd1000;
    req_data = {dw[3], dw[2], dw[1], dw[0]};
    test_reset();
    test_single();
    test_rr_bl1();
    test_burst2();
    test_fill();
    test_burst_break();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
